// File: rtl/mext_issue_stall_unit.sv
// rtl/mext_issue_stall_unit.sv - issue/stall sequencer for M-extension ops in the Execute stage
module mext_issue_stall_unit #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        validE,
    input  logic        flushE,
    input  logic [4:0]  alu_opE,
    input  logic        flagM,
    input  logic        flagD,
    input  logic [31:0] result_m,
    output logic        startE,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        mdu_valid,
    output logic [31:0] mdu_result,
    output logic        mdu_timeout,
    output logic        busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  wdog;
    logic              timeout_pend;
    logic              stall;
    logic              is_m;
    logic              launch;
    logic              flag;
    logic              wdog_exp;

    assign is_m     = validE && (alu_opE >= 5'b01011) && (alu_opE <= 5'b10010);
    assign launch   = is_m && !flushE;
    assign flag     = flagM || flagD;
    assign wdog_exp = (wdog == WDOG_LAST);

    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        startE      = 1'b0;
        mdu_valid   = 1'b0;
        mdu_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                stall = launch;
                if (launch) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                startE    = 1'b1;
                stall     = 1'b1;
                state_nxt = flushE ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                stall = 1'b1;
                // A flush coinciding with completion drops the result; the controller is already idle.
                if (flag && flushE)  state_nxt = S_IDLE;
                else if (flag)       state_nxt = S_DONE;
                else if (flushE)     state_nxt = S_DRAIN;
                else if (wdog_exp)   state_nxt = S_DONE;
            end
            S_DONE: begin
                mdu_valid   = 1'b1;
                mdu_timeout = timeout_pend;
                state_nxt   = S_IDLE;
            end
            S_DRAIN: begin
                stall = is_m;
                if (flag) begin
                    state_nxt = S_IDLE;
                end else if (wdog_exp) begin
                    state_nxt   = S_IDLE;
                    mdu_timeout = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            wdog         <= '0;
            mdu_result   <= '0;
            timeout_pend <= 1'b0;
        end else begin
            state <= state_nxt;

            // Entering DRAIN restarts the watchdog so the drain gets a full budget.
            if (state != S_WAIT && state != S_DRAIN)
                wdog <= '0;
            else if (state == S_WAIT && flushE && !flag)
                wdog <= '0;
            else if (!wdog_exp)
                wdog <= wdog + CNT_W'(1);

            if (state == S_WAIT && !flushE) begin
                if (flag) begin
                    mdu_result   <= result_m;
                    timeout_pend <= 1'b0;
                end else if (wdog_exp) begin
                    mdu_result   <= '0;
                    timeout_pend <= 1'b1;
                end
            end
        end
    end

    assign stallF = stall;
    assign stallD = stall;
    assign stallE = stall;
    assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_mext_issue_stall_unit.sv
// tb/tb_mext_issue_stall_unit.sv - scoreboard bench for mext_issue_stall_unit
module tb_mext_issue_stall_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        validE;
    logic        flushE;
    logic [4:0]  alu_opE;
    logic        flagM;
    logic        flagD;
    logic [31:0] result_m;
    logic        startE;
    logic        stallF;
    logic        stallD;
    logic        stallE;
    logic        mdu_valid;
    logic [31:0] mdu_result;
    logic        mdu_timeout;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_MUL  = 5'b01011;
    localparam logic [4:0] OP_MULH = 5'b01100;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_REM  = 5'b10001;

    mext_issue_stall_unit #(.TIMEOUT_CYCLES(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .validE      (validE),
        .flushE      (flushE),
        .alu_opE     (alu_opE),
        .flagM       (flagM),
        .flagD       (flagD),
        .result_m    (result_m),
        .startE      (startE),
        .stallF      (stallF),
        .stallD      (stallD),
        .stallE      (stallE),
        .mdu_valid   (mdu_valid),
        .mdu_result  (mdu_result),
        .mdu_timeout (mdu_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample outputs mid-cycle against expectations, then advance.
    task automatic tick(input string tag, input logic s, input logic st, input logic b, input logic v);
        exp_t e;
        @(negedge clk);
        check({tag, "_startE"},    32'(startE),    32'(s));
        check({tag, "_stallE"},    32'(stallE),    32'(st));
        check({tag, "_stallF"},    32'(stallF),    32'(st));
        check({tag, "_stallD"},    32'(stallD),    32'(st));
        check({tag, "_busy"},      32'(busy),      32'(b));
        check({tag, "_mdu_valid"}, 32'(mdu_valid), 32'(v));
        if (mdu_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_mdu_result"},  mdu_result,         e.res);
            check({tag, "_mdu_timeout"}, 32'(mdu_timeout),   32'(e.to));
        end else begin
            check({tag, "_mdu_timeout"}, 32'(mdu_timeout), 32'(0));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] r, input logic t);
        exp_t e;
        e.res = r;
        e.to  = t;
        sb.push_back(e);
    endtask

    task automatic set_op(input logic v, input logic [4:0] op);
        validE  = v;
        alu_opE = op;
    endtask

    initial begin
        rst = 1'b1; validE = 1'b0; flushE = 1'b0; alu_opE = OP_ADD;
        flagM = 1'b0; flagD = 1'b0; result_m = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        tick("rst", 0, 0, 0, 0);
        check("rst_result", mdu_result, 32'h0);
        rst = 1'b0;

        // MUL with completion four cycles after launch
        set_op(1, OP_MUL);
        tick("mul_c0", 0, 1, 0, 0);
        tick("mul_c1", 1, 1, 1, 0);
        tick("mul_c2", 0, 1, 1, 0);
        tick("mul_c3", 0, 1, 1, 0);
        flagM = 1'b1; result_m = 32'h12345678; push_exp(32'h12345678, 1'b0);
        tick("mul_c4", 0, 1, 1, 0);
        flagM = 1'b0; result_m = 32'hDEADBEEF;
        tick("mul_c5", 0, 0, 1, 1);
        set_op(0, OP_ADD);
        tick("mul_c6", 0, 0, 0, 0);

        // Non-M op never engages the unit
        set_op(1, OP_ADD);
        for (int i = 0; i < 10; i++) tick("add", 0, 0, 0, 0);
        set_op(0, OP_ADD);

        // DIV flushed in WAIT, drained until flagD
        set_op(1, OP_DIV);
        tick("dfl_c0", 0, 1, 0, 0);
        tick("dfl_c1", 1, 1, 1, 0);
        tick("dfl_c2", 0, 1, 1, 0);
        flushE = 1'b1;
        tick("dfl_c3", 0, 1, 1, 0);
        flushE = 1'b0; set_op(0, OP_ADD);
        tick("dfl_c4", 0, 0, 1, 0);
        set_op(1, OP_MUL);
        tick("dfl_c5_hold", 0, 1, 1, 0);
        set_op(0, OP_ADD);
        tick("dfl_c6", 0, 0, 1, 0);
        flagD = 1'b1; result_m = 32'h0BAD0BAD;
        tick("dfl_c7", 0, 0, 1, 0);
        flagD = 1'b0;
        tick("dfl_c8", 0, 0, 0, 0);

        // MULH with no completion: watchdog forces a zero result
        set_op(1, OP_MULH);
        tick("to_c0", 0, 1, 0, 0);
        push_exp(32'h0, 1'b1);
        tick("to_c1", 1, 1, 1, 0);
        for (int i = 0; i < 64; i++) tick("to_wait", 0, 1, 1, 0);
        tick("to_done", 0, 0, 1, 1);
        set_op(0, OP_ADD);
        tick("to_idle", 0, 0, 0, 0);

        // DIV then REM back to back
        set_op(1, OP_DIV);
        tick("b2b_c0", 0, 1, 0, 0);
        tick("b2b_c1", 1, 1, 1, 0);
        tick("b2b_c2", 0, 1, 1, 0);
        tick("b2b_c3", 0, 1, 1, 0);
        flagD = 1'b1; result_m = 32'h5; push_exp(32'h5, 1'b0);
        tick("b2b_c4", 0, 1, 1, 0);
        flagD = 1'b0;
        tick("b2b_c5", 0, 0, 1, 1);
        set_op(1, OP_REM);
        tick("b2b_c6", 0, 1, 0, 0);
        tick("b2b_c7", 1, 1, 1, 0);
        tick("b2b_c8", 0, 1, 1, 0);
        flagD = 1'b1; result_m = 32'hA5A5; push_exp(32'hA5A5, 1'b0);
        tick("b2b_c9", 0, 1, 1, 0);
        flagD = 1'b0;
        tick("b2b_c10", 0, 0, 1, 1);
        set_op(0, OP_ADD);
        tick("b2b_c11", 0, 0, 0, 0);

        // Flag and flush in the same WAIT cycle: result dropped, straight to IDLE
        set_op(1, OP_MUL);
        tick("ff_c0", 0, 1, 0, 0);
        tick("ff_c1", 1, 1, 1, 0);
        tick("ff_c2", 0, 1, 1, 0);
        flagM = 1'b1; flushE = 1'b1; result_m = 32'h77777777;
        tick("ff_c3", 0, 1, 1, 0);
        flagM = 1'b0; flushE = 1'b0; set_op(0, OP_ADD);
        tick("ff_c4", 0, 0, 0, 0);
        check("ff_result_kept", mdu_result, 32'hA5A5);

        // Reset mid-WAIT discards the op
        set_op(1, OP_MUL);
        tick("rw_c0", 0, 1, 0, 0);
        tick("rw_c1", 1, 1, 1, 0);
        tick("rw_c2", 0, 1, 1, 0);
        rst = 1'b1; set_op(0, OP_ADD);
        tick("rw_c3", 0, 1, 1, 0);
        rst = 1'b0;
        tick("rw_c4", 0, 0, 0, 0);
        check("rw_result", mdu_result, 32'h0);
        flagM = 1'b1; result_m = 32'h99999999;
        tick("rw_c5", 0, 0, 0, 0);
        flagM = 1'b0;
        tick("rw_c6", 0, 0, 0, 0);

        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
